fiber_mshr: RTL and testbench
=============================

Name: fiber_mshr

Overview:
- Miss-status holding register file placed between a fiber cache bank and the DRAM crossbar.
- Tracks up to ENTRIES outstanding line fetches and merges duplicate misses to the same address.
- Issues DRAM reads tagged with an entry id; accepts out-of-order tagged responses.
- Hands each returned line back to the bank as a fill, flagging whether a merged READ_REQ waits on it.

Parameters:
- DATA_WIDTH, 16, DRAM/fill data word width.
- ADDR_WIDTH, 64, line address width.
- ENTRIES, 4, number of MSHR entries (>=2, power of two).
- ID_WIDTH, $clog2(ENTRIES), DRAM transaction id width (derived).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_miss_valid  in  1  bank miss request valid
- i_miss_type  in  4  FETCH_REQ or READ_REQ (one-hot, package constants)
- i_miss_addr  in  ADDR_WIDTH  miss line address
- o_miss_ready  out  1  miss accepted when valid&ready
- o_dram_req_valid  out  1  DRAM read request valid
- o_dram_req_addr  out  ADDR_WIDTH  DRAM read address
- o_dram_req_id  out  ID_WIDTH  entry id
- i_dram_req_ready  in  1  DRAM accepts request
- i_dram_rsp_valid  in  1  DRAM response valid
- i_dram_rsp_id  in  ID_WIDTH  response entry id
- i_dram_rsp_data  in  DATA_WIDTH  response data
- o_dram_rsp_ready  out  1  constant 1 after reset
- o_fill_valid  out  1  fill to bank valid
- o_fill_addr  out  ADDR_WIDTH  fill address
- o_fill_data  out  DATA_WIDTH  fill data
- o_fill_read  out  1  a READ_REQ was merged into this entry; bank must forward data to PE
- i_fill_ready  in  1  bank accepts fill
- o_outstanding  out  $clog2(ENTRIES+1)  count of non-IDLE entries
- o_err  out  1  sticky: response to an entry not in ISSUED

Behaviour:
- Per-entry state: IDLE -> PEND (allocated) -> ISSUED (DRAM accepted) -> FILL (data held) -> IDLE (fill accepted). Per-entry fields: addr, data, read flag.
- Reset: all entries IDLE. All outputs 0 except o_dram_rsp_ready=1 from the first cycle after reset. Reset mid-operation discards every entry; the in-flight req/fill valid drops the next cycle.
- Match: combinational compare of i_miss_addr against all non-IDLE entries; at most one can match.
- Merge on match: no DRAM request. A READ_REQ sets the entry's read flag; a FETCH_REQ changes nothing.
- Merge exception: if the matching entry is completing its fill handshake this cycle, o_miss_ready=0.
- Allocate on no match: lowest-index IDLE entry (state at cycle start) -> PEND; read flag = (type==READ_REQ).
- Back-pressure: no match and no IDLE entry -> o_miss_ready=0. An entry freed this cycle is allocatable next cycle.
- Invalid i_miss_type (not FETCH/READ) with valid: accepted and dropped; no state change.
- DRAM issue: registered. When not presenting, latch the lowest-index PEND entry and assert valid next cycle; addr/id stay stable until i_dram_req_ready. Handshake -> entry ISSUED.
- Latency: miss accepted in cycle N -> o_dram_req_valid in N+1 at the earliest.
- Response: i_dram_rsp_id selects the entry. If ISSUED: store data -> FILL. Otherwise the response is dropped and o_err is set (cleared only by reset).
- Same-cycle response and READ merge on that entry: both apply; the entry ends in FILL with read=1.
- Fill: registered selection of the lowest-index FILL entry, output stable until i_fill_ready. Fill valid at M+1 for a response in cycle M, at the earliest. Handshake -> entry IDLE.
- o_outstanding: registered count of non-IDLE entries, updated each cycle.
- Simultaneous events (allocate, issue, response, fill, each on different entries) are all processed in the same cycle.

Decomposition:
- fiber_pkg holds:
  - request constants FETCH_REQ=4'b0001, READ_REQ=4'b0010, WRITE_REQ=4'b0100, CONSUME_REQ=4'b1000;
  - entry state encoding (IDLE/PEND/ISSUED/FILL, 2 bits).
- One sub-module, fiber_lowest_idx: parametrised priority encoder (ENTRIES-bit vector -> index + found flag), instanced three times (alloc, issue, fill).

Test Plan:
- Reset then FETCH addr 0x00000000FFFFFFFF:
  - req_valid, addr=0x00000000FFFFFFFF, id=0 one cycle after acceptance;
  - response id=0 data=0x0000 -> fill_valid, data=0x0000, read=0 the next cycle;
  - o_outstanding returns 1->0 after the fill handshake.
- FETCH then READ to the same addr before the response: exactly one DRAM request; fill shows read=1; o_outstanding peaks at 1.
- Fill: 4 distinct FETCHes with i_dram_req_ready=1 -> ids 0,1,2,3 in order.
  - A 5th distinct miss sees o_miss_ready=0 until a fill handshake frees an entry, then it allocates id of the freed entry.
- Out-of-order responses ids 2,0 with data 0xAAAA, 0x5555 -> fills in order id0 (0x5555) then id2 (0xAAAA) with i_fill_ready=1; addresses match the originals.
- Stalls: hold i_dram_req_ready=0 and i_fill_ready=0 for 5 cycles -> req and fill outputs remain stable and valid. A response with id=3 while entry 3 is IDLE -> o_err=1 and stays 1.
- Assert i_reset while 2 entries are ISSUED -> next cycle all valids 0, o_outstanding=0, o_err=0; a new FETCH allocates id 0.

Source files
------------

// File: rtl/fiber_pkg.sv
// Shared request encodings and per-entry state for the fiber MSHR.
package fiber_pkg;

  localparam logic [3:0] FETCH_REQ   = 4'b0001;
  localparam logic [3:0] READ_REQ    = 4'b0010;
  localparam logic [3:0] WRITE_REQ   = 4'b0100;
  localparam logic [3:0] CONSUME_REQ = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_FILL   = 2'd3
  } entry_state_e;

endpackage

// File: rtl/fiber_lowest_idx.sv
// Priority encoder: index of the lowest set bit plus a found flag.
module fiber_lowest_idx #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fiber_mshr.sv
// Miss-status holding registers: merges duplicate line misses, issues tagged DRAM
// reads, accepts out-of-order responses and returns each line to the bank as a fill.
module fiber_mshr
  import fiber_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int ENTRIES    = 4,
  parameter int ID_WIDTH   = $clog2(ENTRIES),
  parameter int CNT_WIDTH  = $clog2(ENTRIES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_miss_valid,
  input  logic [3:0]            i_miss_type,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  output logic                  o_miss_ready,
  output logic                  o_dram_req_valid,
  output logic [ADDR_WIDTH-1:0] o_dram_req_addr,
  output logic [ID_WIDTH-1:0]   o_dram_req_id,
  input  logic                  i_dram_req_ready,
  input  logic                  i_dram_rsp_valid,
  input  logic [ID_WIDTH-1:0]   i_dram_rsp_id,
  input  logic [DATA_WIDTH-1:0] i_dram_rsp_data,
  output logic                  o_dram_rsp_ready,
  output logic                  o_fill_valid,
  output logic [ADDR_WIDTH-1:0] o_fill_addr,
  output logic [DATA_WIDTH-1:0] o_fill_data,
  output logic                  o_fill_read,
  input  logic                  i_fill_ready,
  output logic [CNT_WIDTH-1:0]  o_outstanding,
  output logic                  o_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid output keeps its payload unchanged until that edge.

  entry_state_e          state_q [ENTRIES];
  entry_state_e          state_d [ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_q  [ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_d  [ENTRIES];
  logic [DATA_WIDTH-1:0] data_q  [ENTRIES];
  logic [DATA_WIDTH-1:0] data_d  [ENTRIES];
  logic [ENTRIES-1:0]    read_q, read_d;

  logic                  req_valid_q, fill_valid_q, rsp_ready_q, err_q;
  logic [ID_WIDTH-1:0]   req_id_q, fill_id_q;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [ENTRIES-1:0]    idle_vec, match_vec, pend_vec, fillc_vec;
  logic [ID_WIDTH-1:0]   alloc_idx, issue_idx, fill_idx, match_idx;
  logic                  alloc_found, issue_found, fill_found, match_any;
  logic                  type_ok, is_read, can_accept, miss_acc, alloc_now;
  logic                  req_fire, fill_fire, rsp_fire, rsp_ok;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      idle_vec[i]  = (state_q[i] == ST_IDLE);
      match_vec[i] = (state_q[i] != ST_IDLE) && (addr_q[i] == i_miss_addr);
    end
  end

  always_comb begin
    match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match_vec[i]) match_idx = ID_WIDTH'(i);
    end
  end

  fiber_lowest_idx #(.N(ENTRIES), .IDX_W(ID_WIDTH)) u_alloc_sel (
    .vec_i(idle_vec), .idx_o(alloc_idx), .found_o(alloc_found)
  );

  always_comb begin
    match_any = |match_vec;
    type_ok   = (i_miss_type == FETCH_REQ) || (i_miss_type == READ_REQ);
    is_read   = (i_miss_type == READ_REQ);
    req_fire  = req_valid_q && i_dram_req_ready;
    fill_fire = fill_valid_q && i_fill_ready;
    rsp_fire  = i_dram_rsp_valid && rsp_ready_q;
    rsp_ok    = (state_q[i_dram_rsp_id] == ST_ISSUED);
    // A line leaving this cycle cannot absorb a merge; the miss retries next cycle.
    if (!type_ok)       can_accept = 1'b1;
    else if (match_any) can_accept = !(fill_fire && (fill_id_q == match_idx));
    else                can_accept = alloc_found;
    o_miss_ready = i_miss_valid && can_accept;
    miss_acc     = o_miss_ready && type_ok;
    alloc_now    = miss_acc && !match_any;
  end

  // Candidates include the entry allocated (or answered) this cycle so the request
  // (or fill) can appear on the very next cycle; the one already presented is skipped.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      pend_vec[i]  = ((state_q[i] == ST_PEND) || (alloc_now && (alloc_idx == ID_WIDTH'(i))))
                     && !(req_valid_q && (req_id_q == ID_WIDTH'(i)));
      fillc_vec[i] = ((state_q[i] == ST_FILL) ||
                      (rsp_fire && rsp_ok && (i_dram_rsp_id == ID_WIDTH'(i))))
                     && !(fill_valid_q && (fill_id_q == ID_WIDTH'(i)));
    end
  end

  fiber_lowest_idx #(.N(ENTRIES), .IDX_W(ID_WIDTH)) u_issue_sel (
    .vec_i(pend_vec), .idx_o(issue_idx), .found_o(issue_found)
  );

  fiber_lowest_idx #(.N(ENTRIES), .IDX_W(ID_WIDTH)) u_fill_sel (
    .vec_i(fillc_vec), .idx_o(fill_idx), .found_o(fill_found)
  );

  always_comb begin
    count_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
      read_d[i]  = read_q[i];
      if (alloc_now && (alloc_idx == ID_WIDTH'(i))) begin
        state_d[i] = ST_PEND;
        addr_d[i]  = i_miss_addr;
        read_d[i]  = is_read;
      end
      if (miss_acc && match_any && is_read && (match_idx == ID_WIDTH'(i))) read_d[i] = 1'b1;
      if (req_fire && (req_id_q == ID_WIDTH'(i))) state_d[i] = ST_ISSUED;
      if (rsp_fire && rsp_ok && (i_dram_rsp_id == ID_WIDTH'(i))) begin
        state_d[i] = ST_FILL;
        data_d[i]  = i_dram_rsp_data;
      end
      if (fill_fire && (fill_id_q == ID_WIDTH'(i))) begin
        state_d[i] = ST_IDLE;
        read_d[i]  = 1'b0;
      end
      if (state_d[i] != ST_IDLE) count_d = count_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= ST_IDLE;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      read_q       <= '0;
      req_valid_q  <= 1'b0;
      req_id_q     <= '0;
      fill_valid_q <= 1'b0;
      fill_id_q    <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      rsp_ready_q  <= 1'b1;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        addr_q[i]  <= addr_d[i];
        data_q[i]  <= data_d[i];
      end
      read_q  <= read_d;
      count_q <= count_d;
      err_q   <= err_q || (rsp_fire && !rsp_ok);
      if (!req_valid_q || req_fire) begin
        req_valid_q <= issue_found;
        if (issue_found) req_id_q <= issue_idx;
      end
      if (!fill_valid_q || fill_fire) begin
        fill_valid_q <= fill_found;
        if (fill_found) fill_id_q <= fill_idx;
      end
    end
  end

  // Payloads come from entry storage, which cannot change while the entry is presented
  // (except the read flag, which may only rise from a late merge).
  assign o_dram_req_valid = req_valid_q;
  assign o_dram_req_addr  = addr_q[req_id_q];
  assign o_dram_req_id    = req_id_q;
  assign o_dram_rsp_ready = rsp_ready_q;
  assign o_fill_valid     = fill_valid_q;
  assign o_fill_addr      = addr_q[fill_id_q];
  assign o_fill_data      = data_q[fill_id_q];
  assign o_fill_read      = read_q[fill_id_q];
  assign o_outstanding    = count_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_fiber_mshr.sv
// Directed bench for fiber_mshr: expected DRAM requests and fills are queued by the
// stimulus and popped by a monitor on every accepted handshake.
module tb_fiber_mshr;
  import fiber_pkg::*;

  logic        clk, rst;
  logic        miss_valid, miss_ready;
  logic [3:0]  miss_type;
  logic [63:0] miss_addr;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_id;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        fill_valid, fill_ready, fill_read;
  logic [63:0] fill_addr;
  logic [15:0] fill_data;
  logic [2:0]  outstanding;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [65:0] exp_req_q[$];
  logic [80:0] exp_fill_q[$];

  localparam logic [63:0] A1 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] A2 = 64'hDEAD_BEEF_0000_1000;
  localparam logic [63:0] B0 = 64'h100, B1 = 64'h200, B2 = 64'h300, B3 = 64'h400;
  localparam logic [63:0] B4 = 64'h500, B5 = 64'h600, B6 = 64'h700, B7 = 64'h800;
  localparam logic [63:0] B8 = 64'h900;

  fiber_mshr dut (
    .i_clk(clk), .i_reset(rst),
    .i_miss_valid(miss_valid), .i_miss_type(miss_type), .i_miss_addr(miss_addr),
    .o_miss_ready(miss_ready),
    .o_dram_req_valid(req_valid), .o_dram_req_addr(req_addr), .o_dram_req_id(req_id),
    .i_dram_req_ready(req_ready),
    .i_dram_rsp_valid(rsp_valid), .i_dram_rsp_id(rsp_id), .i_dram_rsp_data(rsp_data),
    .o_dram_rsp_ready(rsp_ready),
    .o_fill_valid(fill_valid), .o_fill_addr(fill_addr), .o_fill_data(fill_data),
    .o_fill_read(fill_read), .i_fill_ready(fill_ready),
    .o_outstanding(outstanding), .o_err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_miss(input logic [3:0] t, input logic [63:0] a);
    int n;
    miss_valid = 1'b1; miss_type = t; miss_addr = a; n = 0;
    @(negedge clk);
    while (!miss_ready && n < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    check("miss_accept", miss_ready, 1'b1);
    @(posedge clk); #1;
    miss_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] id, input logic [15:0] d);
    rsp_valid = 1'b1; rsp_id = id; rsp_data = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        check("req_expected", exp_req_q.size() > 0, 1'b1);
        if (exp_req_q.size() > 0) check("req_addr_id", {req_addr, req_id}, exp_req_q.pop_front());
      end
      if (fill_valid && fill_ready) begin
        check("fill_expected", exp_fill_q.size() > 0, 1'b1);
        if (exp_fill_q.size() > 0)
          check("fill_addr_data_read", {fill_addr, fill_data, fill_read}, exp_fill_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; miss_valid = 0; miss_type = FETCH_REQ; miss_addr = '0;
    req_ready = 1'b1; rsp_valid = 0; rsp_id = '0; rsp_data = '0; fill_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_err", err, 1'b0);
    check("rst_rsp_ready", rsp_ready, 1'b1);
    check("rst_miss_ready", miss_ready, 1'b0);
    tick();

    // single fetch round trip
    exp_req_q.push_back({A1, 2'd0});
    do_miss(FETCH_REQ, A1);
    @(negedge clk);
    check("req_latency", req_valid, 1'b1);
    check("outstanding_one", outstanding, 3'd1);
    tick();
    exp_fill_q.push_back({A1, 16'h0000, 1'b0});
    respond(2'd0, 16'h0000);
    @(negedge clk);
    check("fill_latency", fill_valid, 1'b1);
    tick();
    @(negedge clk);
    check("outstanding_zero", outstanding, 3'd0);
    check("fill_done", fill_valid, 1'b0);
    tick();

    // fetch + merged read: one DRAM request, fill flagged read
    exp_req_q.push_back({A2, 2'd0});
    do_miss(FETCH_REQ, A2);
    do_miss(READ_REQ, A2);
    @(negedge clk);
    check("merge_outstanding", outstanding, 3'd1);
    tick();
    exp_fill_q.push_back({A2, 16'h1234, 1'b1});
    respond(2'd0, 16'h1234);
    repeat (3) tick();
    @(negedge clk);
    check("merge_drained", outstanding, 3'd0);
    tick();

    // fill all entries, back-pressure, out-of-order responses
    fill_ready = 1'b0;
    exp_req_q.push_back({B0, 2'd0});
    exp_req_q.push_back({B1, 2'd1});
    exp_req_q.push_back({B2, 2'd2});
    exp_req_q.push_back({B3, 2'd3});
    do_miss(FETCH_REQ, B0);
    do_miss(FETCH_REQ, B1);
    do_miss(FETCH_REQ, B2);
    do_miss(FETCH_REQ, B3);
    miss_valid = 1'b1; miss_type = FETCH_REQ; miss_addr = B4;
    @(negedge clk);
    check("full_backpressure", miss_ready, 1'b0);
    tick(); tick();
    respond(2'd1, 16'h1111);
    respond(2'd2, 16'hAAAA);
    respond(2'd0, 16'h5555);
    @(negedge clk);
    check("full_still_blocked", miss_ready, 1'b0);
    check("full_outstanding", outstanding, 3'd4);
    check("fill_head_addr", fill_addr, B1);
    tick();
    exp_fill_q.push_back({B1, 16'h1111, 1'b0});
    exp_fill_q.push_back({B0, 16'h5555, 1'b0});
    exp_fill_q.push_back({B2, 16'hAAAA, 1'b0});
    exp_req_q.push_back({B4, 2'd1});
    fill_ready = 1'b1;
    do_miss(FETCH_REQ, B4);
    repeat (4) tick();
    @(negedge clk);
    check("after_ooo_outstanding", outstanding, 3'd2);
    tick();

    // simultaneous stall on request and fill outputs
    req_ready = 1'b0; fill_ready = 1'b0;
    respond(2'd3, 16'h3333);
    do_miss(FETCH_REQ, B5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_req", {req_valid, req_addr, req_id}, {1'b1, B5, 2'd0});
      check("stall_fill", {fill_valid, fill_addr, fill_data}, {1'b1, B3, 16'h3333});
      tick();
    end
    exp_req_q.push_back({B5, 2'd0});
    exp_fill_q.push_back({B3, 16'h3333, 1'b0});
    req_ready = 1'b1; fill_ready = 1'b1;
    tick();
    exp_fill_q.push_back({B4, 16'h4444, 1'b0});
    respond(2'd1, 16'h4444);
    tick(); tick();

    // response to an idle entry sets the sticky error
    respond(2'd3, 16'h7777);
    @(negedge clk);
    check("err_set", err, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", err, 1'b1);
    tick();

    // reset with entries in flight
    exp_req_q.push_back({B6, 2'd1});
    do_miss(FETCH_REQ, B6);
    tick(); tick();
    req_ready = 1'b0;
    do_miss(FETCH_REQ, B7);
    @(negedge clk);
    check("pre_reset_outstanding", outstanding, 3'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_valid", req_valid, 1'b0);
    check("midrst_fill_valid", fill_valid, 1'b0);
    check("midrst_outstanding", outstanding, 3'd0);
    check("midrst_err", err, 1'b0);
    tick();
    req_ready = 1'b1;
    exp_req_q.push_back({B8, 2'd0});
    do_miss(FETCH_REQ, B8);
    repeat (3) tick();

    // unsupported type is accepted and dropped
    miss_valid = 1'b1; miss_type = WRITE_REQ; miss_addr = B0;
    @(negedge clk);
    check("invalid_type_ready", miss_ready, 1'b1);
    tick();
    miss_valid = 1'b0;
    @(negedge clk);
    check("invalid_type_nochange", outstanding, 3'd1);
    tick();
    exp_fill_q.push_back({B8, 16'h8888, 1'b0});
    respond(2'd0, 16'h8888);
    repeat (4) tick();
    @(negedge clk);
    check("final_outstanding", outstanding, 3'd0);
    check("req_q_drained", exp_req_q.size(), 0);
    check("fill_q_drained", exp_fill_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
